change_dispenser: RTL

- Coin-return end of the vending machine datapath; it is the counterpart of the coin-accept and next-state logic.
- Takes a return amount from the controller (return_total at the return state) and drives o_return_coin one coin per cycle, greedy largest-first, until the amount is exhausted or no coin fits.
- Paces coin emission with a hopper-ready handshake and reports completion plus any unreturnable residue.

---
 rtl/change_dispenser.sv | 114 +++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// change_dispenser: greedy largest-first coin return, one coin per hopper-ready cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [TOTAL_BITS-1:0] i_return_amount,
    input  logic                  i_hopper_ready,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_remaining,
    output logic [TOTAL_BITS-1:0] o_residue
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [NUM_COINS-1:0]    coin_next;
    logic [TOTAL_BITS-1:0]   remaining_next;
    logic [TOTAL_BITS-1:0]   residue_next;
    logic                    fit;
    logic [NUM_COINS-1:0]    sel_onehot;
    logic [TOTAL_BITS-1:0]   sel_value;

    // Indices beyond the defined denominations never fit.
    function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
        case (k)
            0:       coin_value = TOTAL_BITS'(COIN0_VALUE);
            1:       coin_value = TOTAL_BITS'(COIN1_VALUE);
            2:       coin_value = TOTAL_BITS'(COIN2_VALUE);
            default: coin_value = '1;
        endcase
    endfunction

    // Denominations ascend with index, so the last fitting index is the largest coin.
    always_comb begin
        fit        = 1'b0;
        sel_onehot = '0;
        sel_value  = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_value(k) <= o_remaining) begin
                fit        = 1'b1;
                sel_onehot = NUM_COINS'(1) << k;
                sel_value  = coin_value(k);
            end
        end
    end

    always_comb begin
        next_state     = state;
        coin_next      = '0;
        remaining_next = o_remaining;
        residue_next   = o_residue;
        case (state)
            IDLE: begin
                if (i_start) begin
                    residue_next   = '0;
                    remaining_next = i_return_amount;
                    next_state     = (i_return_amount != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (!fit) begin
                    next_state   = DONE;
                    residue_next = o_remaining;
                end else if (i_hopper_ready) begin
                    coin_next      = sel_onehot;
                    remaining_next = o_remaining - sel_value;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            o_return_coin <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_remaining   <= '0;
            o_residue     <= '0;
        end else begin
            state         <= next_state;
            o_return_coin <= coin_next;
            o_busy        <= (next_state == ISSUE);
            o_done        <= (next_state == DONE);
            o_remaining   <= remaining_next;
            o_residue     <= residue_next;
        end
    end

endmodule
`default_nettype wire
